// File: rtl/tmds_decoder_align_pkg.sv
// Shared TMDS receive definitions: control tokens, alignment FSM states, decoded symbol struct.
// Token values are shared with the transmit-side encoder and must stay bit-identical to it.
package tmds_decoder_align_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;     // {c1, c0}
    logic [7:0] dat;
  } sym_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: 10-bit word -> control-token flag, {c1,c0} and 8-bit data.
// Zero latency; no flow control.
module tmds_symbol_decode
  import tmds_decoder_align_pkg::*;
(
  input  logic [9:0] din,
  output sym_t       sym
);

  logic [7:0] q;

  always_comb begin
    q   = din[9] ? ~din[7:0] : din[7:0];
    sym = '0;
    sym.dat[0] = q[0];
    // din[8] tells whether the encoder chained with XOR or XNOR
    for (int i = 1; i < 8; i++) begin
      sym.dat[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    case (din)
      CTRL_TOKEN_00: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b00; end
      CTRL_TOKEN_01: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b01; end
      CTRL_TOKEN_10: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b10; end
      CTRL_TOKEN_11: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b11; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tmds_decoder_align.sv
// Per-channel TMDS receiver: bitslip-driven word alignment on control tokens, then symbol decode.
// Latency 2 cycles din -> dout/c0/c1/de; free-running, no backpressure.
module tmds_decoder_align
  import tmds_decoder_align_pkg::*;
#(
  parameter int SEARCH_CYCLES = 1024,
  parameter int SLIP_WAIT     = 8,
  parameter int LOCK_RUN      = 8,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic       pixelclk,
  input  logic       rst,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_cnt
);

  localparam int TIMER_W = $clog2(SEARCH_CYCLES) + 1;
  localparam int RUN_W   = $clog2(LOCK_RUN) + 1;
  localparam int WAIT_W  = $clog2(SLIP_WAIT) + 1;
  localparam int LOSS_W  = $clog2(LOSS_CYCLES) + 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEARCH_CYCLES - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_RUN - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CYCLES - 1);

  logic [9:0]         din_q;
  sym_t               sym;
  align_state_t       state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [RUN_W-1:0]   run;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [LOSS_W-1:0]  loss;
  logic               run_done, timer_done, wait_done, loss_done;
  logic               bitslip_nxt;

  always_ff @(posedge pixelclk) begin
    if (rst) din_q <= '0;
    else     din_q <= din;
  end

  tmds_symbol_decode u_sym_dec (
    .din (din_q),
    .sym (sym)
  );

  assign run_done   = sym.is_ctrl && (run == RUN_LAST);
  assign timer_done = (timer == TIMER_LAST);
  assign wait_done  = (wait_cnt == WAIT_LAST);
  assign loss_done  = !sym.is_ctrl && (loss == LOSS_LAST);

  always_ff @(posedge pixelclk) begin
    if (rst) state <= ST_SEARCH;
    else     state <= state_nxt;
  end

  // A completed token run takes priority over a simultaneous search timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH: begin
        if (run_done)        state_nxt = ST_LOCKED;
        else if (timer_done) state_nxt = ST_SLIP;
      end
      ST_SLIP:   state_nxt = ST_WAIT;
      ST_WAIT:   if (wait_done) state_nxt = ST_SEARCH;
      ST_LOCKED: if (loss_done) state_nxt = ST_SEARCH;
      default:   state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    bitslip_nxt = (state == ST_SLIP);
    locked      = (state == ST_LOCKED);
  end

  // The pulse is registered out of SLIP so a reset landing in SLIP suppresses it
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      bitslip  <= 1'b0;
      slip_cnt <= '0;
      timer    <= '0;
      run      <= '0;
      wait_cnt <= '0;
      loss     <= '0;
    end else begin
      bitslip  <= bitslip_nxt;
      if (state == ST_SLIP) slip_cnt <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
      timer    <= (state == ST_SEARCH && state_nxt == ST_SEARCH) ? timer + TIMER_W'(1) : '0;
      run      <= (state == ST_SEARCH && state_nxt == ST_SEARCH && sym.is_ctrl) ? run + RUN_W'(1) : '0;
      wait_cnt <= (state == ST_WAIT && state_nxt == ST_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      loss     <= (state == ST_LOCKED && state_nxt == ST_LOCKED && !sym.is_ctrl) ? loss + LOSS_W'(1) : '0;
    end
  end

  // c0/c1 keep the last token value across data periods
  always_ff @(posedge pixelclk) begin
    if (rst || state != ST_LOCKED) begin
      dout <= '0;
      de   <= 1'b0;
      c0   <= 1'b0;
      c1   <= 1'b0;
    end else if (sym.is_ctrl) begin
      dout     <= '0;
      de       <= 1'b0;
      {c1, c0} <= sym.ctrl;
    end else begin
      dout <= sym.dat;
      de   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmds_decoder_align.sv
// Directed bench for tmds_decoder_align: reset, lock, decode, bitslip search, lock loss, races.
module tb_tmds_decoder_align;
  import tmds_decoder_align_pkg::*;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] D0  = 10'b0100000000;

  logic       pixelclk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic       c0, c1, de, bitslip, locked;
  logic [3:0] slip_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   consec = 0;
  logic prev_bs = 1'b0;
  int   pulse_at[$];

  always #5 pixelclk = ~pixelclk;

  tmds_decoder_align dut (
    .pixelclk (pixelclk),
    .rst      (rst),
    .din      (din),
    .dout     (dout),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .bitslip  (bitslip),
    .locked   (locked),
    .slip_cnt (slip_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one word, clock it in, sample at the following falling edge
  task automatic step(input logic [9:0] w);
    din = w;
    @(posedge pixelclk);
    @(negedge pixelclk);
    cyc++;
    if (bitslip === 1'b1) begin
      pulses++;
      pulse_at.push_back(cyc);
      if (prev_bs) consec++;
    end
    prev_bs = (bitslip === 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step(10'($urandom));
    chk("rst_dout", dout, 0);
    chk("rst_c0", c0, 0);
    chk("rst_c1", c1, 0);
    chk("rst_de", de, 0);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", locked, 0);
    chk("rst_slip_cnt", slip_cnt, 0);
    chk("rst_state", dut.state, ST_SEARCH);
    rst = 1'b0;
    cyc = 0;
    pulses = 0;
    prev_bs = 1'b0;
    pulse_at.delete();
  endtask

  // word seen by the receiver when the boundary is k bits off
  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[(i + k) % 10];
    return r;
  endfunction

  logic [9:0] vec_w [9];
  logic [7:0] vec_d [9];
  logic       vec_de[9];
  logic [1:0] vec_cc[9];
  int         k;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_w[0] = 10'b1000000000; vec_d[0] = 8'hFF; vec_de[0] = 1'b1; vec_cc[0] = 2'b00;
    vec_w[1] = 10'b0100000000; vec_d[1] = 8'h00; vec_de[1] = 1'b1; vec_cc[1] = 2'b00;
    vec_w[2] = 10'b1011111111; vec_d[2] = 8'hFE; vec_de[2] = 1'b1; vec_cc[2] = 2'b00;
    vec_w[3] = 10'b0001010101; vec_d[3] = 8'h01; vec_de[3] = 1'b1; vec_cc[3] = 2'b00;
    vec_w[4] = 10'b0100001111; vec_d[4] = 8'h11; vec_de[4] = 1'b1; vec_cc[4] = 2'b00;
    vec_w[5] = T11;            vec_d[5] = 8'h00; vec_de[5] = 1'b0; vec_cc[5] = 2'b11;
    vec_w[6] = 10'b0100000000; vec_d[6] = 8'h00; vec_de[6] = 1'b1; vec_cc[6] = 2'b11;
    vec_w[7] = T01;            vec_d[7] = 8'h00; vec_de[7] = 1'b0; vec_cc[7] = 2'b01;
    vec_w[8] = T10;            vec_d[8] = 8'h00; vec_de[8] = 1'b0; vec_cc[8] = 2'b10;

    // lock on an aligned 00-token stream
    do_reset();
    repeat (8) step(T00);
    chk("lock_not_yet", locked, 0);
    step(T00);
    chk("lock_after_8", locked, 1);
    step(T00);
    chk("lock_de", de, 0);
    chk("lock_c1c0", {c1, c0}, 2'b00);
    chk("lock_dout", dout, 0);
    chk("lock_no_slip", pulses, 0);

    // decode, each result visible one step after the word is clocked in
    for (int i = 0; i < 9; i++) begin
      step(vec_w[i]);
      if (i > 0) begin
        chk($sformatf("dec%0d_dout", i - 1), dout, vec_d[i-1]);
        chk($sformatf("dec%0d_de", i - 1), de, vec_de[i-1]);
        chk($sformatf("dec%0d_c1c0", i - 1), {c1, c0}, vec_cc[i-1]);
      end
    end
    step(T00);
    chk("dec8_dout", dout, vec_d[8]);
    chk("dec8_de", de, vec_de[8]);
    chk("dec8_c1c0", {c1, c0}, vec_cc[8]);

    // loss of lock after 4096 data symbols
    do_reset();
    repeat (8) step(T00);
    for (int j = 1; j <= 4096; j++) step(D0);
    chk("loss_held_4096", locked, 1);
    chk("loss_de_locked", de, 1);
    step(D0);
    chk("loss_dropped", locked, 0);
    step(D0);
    chk("loss_de_zero", de, 0);

    // one token at data slot 4000 keeps lock
    do_reset();
    repeat (8) step(T00);
    for (int j = 1; j <= 4097; j++) step(j == 4000 ? T00 : D0);
    chk("loss_token_hold", locked, 1);

    // stream three bits short of alignment
    do_reset();
    k = 7;
    for (int n = 0; n < 5000 && locked !== 1'b1; n++) begin
      step(rot(T00, k));
      if (bitslip === 1'b1) k = (k + 1) % 10;
    end
    chk("mis_locked", locked, 1);
    chk("mis_pulses", pulses, 3);
    chk("mis_slip_cnt", slip_cnt, 3);
    chk("mis_pulse0", pulse_at.size() > 0 ? pulse_at[0] : 0, 1025);
    chk("mis_pulse1", pulse_at.size() > 1 ? pulse_at[1] : 0, 2058);
    chk("mis_pulse2", pulse_at.size() > 2 ? pulse_at[2] : 0, 3091);
    chk("mis_lock_cycle", cyc, 3107);

    // slip_cnt wraps 9 -> 0 on a stream that never aligns
    do_reset();
    for (int n = 0; n < 13500 && pulses < 12; n++) begin
      step(D0);
      if (bitslip === 1'b1) chk($sformatf("wrap_cnt%0d", pulses), slip_cnt, pulses % 10);
    end
    chk("wrap_pulses", pulses, 12);
    chk("wrap_last_cycle", cyc, 12388);

    // eighth token coincides with the search timeout
    do_reset();
    repeat (1015) step(D0);
    repeat (8) step(T00);
    step(D0);
    chk("race_lock", locked, 1);
    repeat (40) step(D0);
    chk("race_no_slip", pulses, 0);
    chk("race_slip_cnt", slip_cnt, 0);

    // reset during the SLIP cycle cancels the pulse
    do_reset();
    repeat (1024) step(D0);
    chk("slip_state", dut.state, ST_SLIP);
    rst = 1'b1;
    step(D0);
    chk("slip_rst_bitslip", bitslip, 0);
    chk("slip_rst_cnt", slip_cnt, 0);
    rst = 1'b0;
    pulses = 0;
    prev_bs = 1'b0;
    repeat (20) step(D0);
    chk("slip_rst_no_pulse", pulses, 0);

    chk("bitslip_consecutive", consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
